ternary_weight_loader: RTL and testbench
========================================

TERNARY_WEIGHT_LOADER -- requirements
Module: ternary_weight_loader

Interface
REQ-001 Parameter MAX_IN_LEN, default 16, number of weight rows (input lanes); SHALL be a power of two, at least 2.
REQ-002 Parameter MAX_OUT_LEN, default 8, number of weight columns; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  begin a load; latches cfg_rows and cfg_cols.
REQ-006 abort  input  1  cancel an in-progress or pending load.
REQ-007 cfg_rows  input  clog2(MAX_IN_LEN)  active rows minus 1.
REQ-008 cfg_cols  input  clog2(MAX_OUT_LEN)  active columns minus 1.
REQ-009 in_valid  input  1  in_data holds a valid bit-plane beat.
REQ-010 in_data  input  MAX_IN_LEN  one bit-plane per beat; bit r maps to row r.
REQ-011 in_ready  output  1  loader accepts a beat this cycle.
REQ-012 swap  input  1  commit the shadow bank to the active bank.
REQ-013 weights_o  output  2*MAX_IN_LEN*MAX_OUT_LEN  active bank; weight (r,c) sits at bits [2*(c*MAX_IN_LEN+r) +: 2], signed two's complement.
REQ-014 busy  output  1  state is not IDLE.
REQ-015 done  output  1  one-cycle pulse when the shadow bank is complete.
REQ-016 err  output  1  sticky flag for an illegal ternary code.

Function
REQ-017 FSM states: IDLE, MSB, LSB, FULL.
REQ-018 A beat is accepted only when in_valid and in_ready are both high; in_ready SHALL be 1 exactly in the MSB and LSB states.
REQ-019 IDLE: on start, latch cfg_rows and cfg_cols, set column counter to 0, clear err, and go to MSB.
REQ-020 MSB: an accepted beat stores bit 1 of shadow (r, count) for r <= cfg_rows, then the FSM goes to LSB.
REQ-021 LSB: an accepted beat stores bit 0 of shadow (r, count) for r <= cfg_rows.
- If count == cfg_cols: go to FULL and pulse done on the following cycle.
- Otherwise: increment count and go to MSB.
REQ-022 Ternary legality: after the LSB beat, a row whose 2-bit code is 2'b10 SHALL have its weight stored as 2'b00 and SHALL set err.
REQ-023 Rows above cfg_rows and columns above cfg_cols SHALL be written as 2'b00 in the shadow bank during the load, never X.
REQ-024 FULL: on swap, copy shadow to active in one cycle; weights_o updates on the edge after the edge that samples swap; then go to IDLE.
REQ-025 swap in any state other than FULL SHALL be ignored.
REQ-026 start in any state other than IDLE SHALL be ignored.
REQ-027 abort in MSB, LSB or FULL returns the FSM to IDLE next cycle; the active bank is unchanged and no done pulse is issued.
REQ-028 abort has priority over a beat accepted in the same cycle, and over swap in the same cycle.
REQ-029 Back-to-back loads SHALL be possible: start in the IDLE cycle after a swap is accepted.
REQ-030 A stall (in_valid low) holds the state and count with no data change, for any duration.
REQ-031 Throughput: 2 accepted beats per column; a full load takes 2*(cfg_cols+1) beats.

Reset
REQ-032 While rst_n is low at an edge:
- FSM goes to IDLE; count = 0.
- done = 0, err = 0, in_ready = 0, busy = 0.
- Both banks and the latched cfg registers clear to zero, so weights_o = 0.
REQ-033 Reset mid-load discards the shadow contents; the next load SHALL behave as the first load after power-up.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the ternary code constants (+1 = 2'b01, 0 = 2'b00, -1 = 2'b11, illegal = 2'b10) and the index-width localparams.
REQ-035 One sub-module, ternary_bank, SHALL hold a MAX_IN_LEN x MAX_OUT_LEN 2-bit register array with per-column, per-bit-plane write enables and a flattened read port; it is instantiated twice (shadow and active).

Verification
REQ-036 Full load: cfg_rows=15, cfg_cols=7; 16 beats alternating 16'hFFFF and 16'h0001; then swap.
- Row 0 of every column = 2'b11 (-1).
- Other rows = 2'b10, so err=1 and they read 2'b00.
- done pulses once.
REQ-037 Partial load: cfg_rows=3, cfg_cols=1; beats 16'h0003, 16'h000F, 16'h0000, 16'h0005.
- Column 0 rows 0-3 = -1, -1, +1, +1.
- Column 1 rows 0-3 = +1, 0, +1, 0.
- All other weights = 0 after swap.
REQ-038 Stall: in_valid toggled randomly for 20 cycles during a load; the final weights equal the no-stall run and in_ready never drops in MSB/LSB.
REQ-039 Abort: load a known pattern and swap it; start a second load and abort after 3 beats.
- weights_o keeps the first pattern.
- done is not asserted.
- busy = 0 the next cycle.
REQ-040 Reset mid-load (rst_n low for 1 cycle during LSB), then a fresh load of all +1: weights_o = all 2'b01 after swap and err = 0.
REQ-041 Ignored controls: swap asserted in MSB, and start asserted in FULL; neither SHALL change weights_o or the FSM state.

Source files
------------

// File: rtl/ternary_weight_loader_pkg.sv
// Shared types for the ternary weight loader: FSM states, ternary codes
// and default index widths.
package ternary_weight_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSB  = 2'd1,
    LSB  = 2'd2,
    FULL = 2'd3
  } state_t;

  localparam logic [1:0] TW_POS  = 2'b01;
  localparam logic [1:0] TW_ZERO = 2'b00;
  localparam logic [1:0] TW_NEG  = 2'b11;
  localparam logic [1:0] TW_ILL  = 2'b10;

  localparam int DEF_IN_LEN  = 16;
  localparam int DEF_OUT_LEN = 8;
  localparam int DEF_ROW_W   = $clog2(DEF_IN_LEN);
  localparam int DEF_COL_W   = $clog2(DEF_OUT_LEN);

  function automatic logic illegal_code(input logic [1:0] c);
    return c == TW_ILL;
  endfunction

endpackage

// File: rtl/ternary_weight_loader_bank.sv
// ternary_bank: IN_LEN x OUT_LEN array of 2-bit weights.
// Ports: clr/ld whole-bank ops, per-column hi/lo plane writes, flat read.
module ternary_bank #(
  parameter int IN_LEN  = 16,
  parameter int OUT_LEN = 8,
  parameter int W       = 2 * IN_LEN * OUT_LEN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               ld,
  input  logic [W-1:0]       ld_data,
  input  logic [OUT_LEN-1:0] we_hi,
  input  logic [OUT_LEN-1:0] we_lo,
  input  logic [IN_LEN-1:0]  d_hi,
  input  logic [IN_LEN-1:0]  d_lo,
  output logic [W-1:0]       rd_flat
);

  // mem[c][r] lands at bits 2*(c*IN_LEN+r) +: 2 of the flat view
  logic [OUT_LEN-1:0][IN_LEN-1:0][1:0] mem;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      mem <= '0;
    end else if (ld) begin
      mem <= ld_data;
    end else begin
      for (int c = 0; c < OUT_LEN; c++) begin
        for (int r = 0; r < IN_LEN; r++) begin
          if (we_hi[c]) mem[c][r][1] <= d_hi[r];
          if (we_lo[c]) mem[c][r][0] <= d_lo[r];
        end
      end
    end
  end

  assign rd_flat = mem;

endmodule

// File: rtl/ternary_weight_loader.sv
// Streams ternary weights in as MSB/LSB bit-planes per column into a
// shadow bank, then commits it to the active bank on swap.
// Ports: start/abort/swap control, cfg_rows/cfg_cols, in_valid/in_ready/
// in_data beat stream, weights_o active bank, busy/done/err status.
module ternary_weight_loader
  import ternary_weight_loader_pkg::*;
#(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [$clog2(MAX_IN_LEN)-1:0]  cfg_rows,
  input  logic [$clog2(MAX_OUT_LEN)-1:0] cfg_cols,
  input  logic                           in_valid,
  input  logic [MAX_IN_LEN-1:0]          in_data,
  output logic                           in_ready,
  input  logic                           swap,
  output logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] weights_o,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int ROW_W = $clog2(MAX_IN_LEN);
  localparam int COL_W = $clog2(MAX_OUT_LEN);
  localparam int W     = 2 * MAX_IN_LEN * MAX_OUT_LEN;

  state_t           state;
  logic [ROW_W-1:0] rows_q;
  logic [COL_W-1:0] cols_q;
  logic [COL_W-1:0] cnt_q;
  logic             swap_q;

  logic [MAX_OUT_LEN-1:0][MAX_IN_LEN-1:0][1:0] shadow_q;

  logic [MAX_IN_LEN-1:0]  row_mask;
  logic [MAX_IN_LEN-1:0]  plane;
  logic [MAX_IN_LEN-1:0]  cur_hi;
  logic [MAX_IN_LEN-1:0]  illegal;
  logic [MAX_OUT_LEN-1:0] col_oh;
  logic [MAX_OUT_LEN-1:0] we_hi;
  logic [MAX_OUT_LEN-1:0] we_lo;
  logic [MAX_IN_LEN-1:0]  d_hi;
  logic [MAX_IN_LEN-1:0]  d_lo;
  logic                   beat;
  logic                   start_ok;
  logic                   swap_ok;

  assign beat     = in_valid && in_ready;
  assign start_ok = (state == IDLE) && start;
  assign swap_ok  = (state == FULL) && swap && !abort;
  assign col_oh   = {{(MAX_OUT_LEN-1){1'b0}}, 1'b1} << cnt_q;
  assign plane    = in_data & row_mask;

  // Inactive rows are forced to zero so they never pick up stray data
  for (genvar r = 0; r < MAX_IN_LEN; r++) begin : g_row
    assign row_mask[r] = (ROW_W'(r) <= rows_q);
    assign cur_hi[r]   = shadow_q[cnt_q][r][1];
    assign illegal[r]  = illegal_code({cur_hi[r], plane[r]});
  end

  // An LSB beat rewrites both planes so a 2'b10 code collapses to zero
  always_comb begin
    we_hi = '0;
    we_lo = '0;
    d_hi  = plane;
    d_lo  = plane;
    if (beat && !abort) begin
      if (state == MSB) begin
        we_hi = col_oh;
      end
      if (state == LSB) begin
        we_hi = col_oh;
        we_lo = col_oh;
        d_hi  = cur_hi & ~illegal;
      end
    end
  end

  ternary_bank #(
    .IN_LEN  (MAX_IN_LEN),
    .OUT_LEN (MAX_OUT_LEN),
    .W       (W)
  ) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_ok),
    .ld      (1'b0),
    .ld_data ({W{1'b0}}),
    .we_hi   (we_hi),
    .we_lo   (we_lo),
    .d_hi    (d_hi),
    .d_lo    (d_lo),
    .rd_flat (shadow_q)
  );

  // Commit lands one edge after swap is sampled; a start in that same
  // cycle clears the shadow only after its old contents are copied.
  ternary_bank #(
    .IN_LEN  (MAX_IN_LEN),
    .OUT_LEN (MAX_OUT_LEN),
    .W       (W)
  ) u_active (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (1'b0),
    .ld      (swap_q),
    .ld_data (shadow_q),
    .we_hi   ({MAX_OUT_LEN{1'b0}}),
    .we_lo   ({MAX_OUT_LEN{1'b0}}),
    .d_hi    ({MAX_IN_LEN{1'b0}}),
    .d_lo    ({MAX_IN_LEN{1'b0}}),
    .rd_flat (weights_o)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rows_q   <= '0;
      cols_q   <= '0;
      cnt_q    <= '0;
      swap_q   <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done   <= 1'b0;
      swap_q <= swap_ok;
      unique case (state)
        IDLE: begin
          if (start) begin
            rows_q   <= cfg_rows;
            cols_q   <= cfg_cols;
            cnt_q    <= '0;
            err      <= 1'b0;
            state    <= MSB;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        MSB: begin
          if (abort) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (beat) begin
            state <= LSB;
          end
        end
        LSB: begin
          if (abort) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (beat) begin
            if (|illegal) err <= 1'b1;
            if (cnt_q == cols_q) begin
              state    <= FULL;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              state <= MSB;
            end
          end
        end
        FULL: begin
          if (abort || swap) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_weight_loader.sv
// Directed + random bench for ternary_weight_loader against a
// per-weight arithmetic reference model.
module tb_ternary_weight_loader;

  localparam int IN  = 16;
  localparam int OUT = 8;
  localparam int W   = 2 * IN * OUT;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          start = 0;
  logic          abort = 0;
  logic [3:0]    cfg_rows = '0;
  logic [2:0]    cfg_cols = '0;
  logic          in_valid = 0;
  logic [IN-1:0] in_data = '0;
  logic          in_ready;
  logic          swap = 0;
  logic [W-1:0]  weights_o;
  logic          busy;
  logic          done;
  logic          err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [IN-1:0] bq[$];

  ternary_weight_loader #(
    .MAX_IN_LEN  (IN),
    .MAX_OUT_LEN (OUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_rows  (cfg_rows),
    .cfg_cols  (cfg_cols),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .swap      (swap),
    .weights_o (weights_o),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && done) done_cnt++;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Weight (r,c) = {hi beat 2c bit r, lo beat 2c+1 bit r}; 2 -> 0 + err
  function automatic logic [W-1:0] model(input int rows, input int cols,
                                         output bit e);
    logic [W-1:0] w;
    int v;
    w = '0;
    e = 0;
    for (int c = 0; c <= cols; c++) begin
      for (int r = 0; r <= rows; r++) begin
        v = 2 * int'(bq[2*c][r]) + int'(bq[2*c+1][r]);
        if (v == 2) begin
          v = 0;
          e = 1;
        end
        w[2*(c*IN+r) +: 2] = 2'(v);
      end
    end
    return w;
  endfunction

  task automatic do_start(input int rows, input int cols);
    @(negedge clk);
    start = 1;
    cfg_rows = 4'(rows);
    cfg_cols = 3'(cols);
    @(negedge clk);
    start = 0;
  endtask

  task automatic run_beats(input bit stall);
    int idx;
    int guard;
    bit v;
    bit drop;
    idx = 0;
    guard = 0;
    drop = 0;
    while (idx < bq.size() && guard < 4000) begin
      @(negedge clk);
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_data = bq[idx];
      if (!in_ready) drop = 1;
      if (v && in_ready) idx++;
      guard++;
    end
    @(negedge clk);
    in_valid = 0;
    chk("beats_taken", W'(idx), W'(bq.size()));
    chk("ready_held", W'(drop), W'(0));
  endtask

  task automatic do_swap(input bit nxt, input int rows, input int cols);
    @(negedge clk);
    swap = 1;
    @(negedge clk);
    swap = 0;
    if (nxt) begin
      start = 1;
      cfg_rows = 4'(rows);
      cfg_cols = 3'(cols);
    end
    @(negedge clk);
    start = 0;
  endtask

  initial begin
    logic [W-1:0] exp_w;
    logic [W-1:0] part_w;
    logic [W-1:0] held_w;
    bit e;
    int d0;
    int rr, rc, nr, nc;

    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_weights", weights_o, '0);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_ready", W'(in_ready), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_err", W'(err), W'(0));

    // Full load: row 0 = -1, everything else illegal -> 0
    bq.delete();
    for (int i = 0; i < 8; i++) begin
      bq.push_back(16'hFFFF);
      bq.push_back(16'h0001);
    end
    exp_w = '0;
    for (int c = 0; c < OUT; c++) exp_w[2*c*IN +: 2] = 2'b11;
    d0 = done_cnt;
    do_start(15, 7);
    chk("full_busy", W'(busy), W'(1));
    run_beats(0);
    chk("full_err", W'(err), W'(1));
    do_swap(0, 0, 0);
    chk("full_w", weights_o, exp_w);
    chk("full_done", W'(done_cnt - d0), W'(1));
    chk("full_idle", W'(busy), W'(0));

    // Partial load with hand-derived values
    part_w = '0;
    part_w[2*(0*IN+0) +: 2] = 2'b11;
    part_w[2*(0*IN+1) +: 2] = 2'b11;
    part_w[2*(0*IN+2) +: 2] = 2'b01;
    part_w[2*(0*IN+3) +: 2] = 2'b01;
    part_w[2*(1*IN+0) +: 2] = 2'b01;
    part_w[2*(1*IN+2) +: 2] = 2'b01;
    bq.delete();
    bq.push_back(16'h0003);
    bq.push_back(16'h000F);
    bq.push_back(16'h0000);
    bq.push_back(16'h0005);
    do_start(3, 1);
    run_beats(0);
    chk("part_err", W'(err), W'(0));
    do_swap(0, 0, 0);
    chk("part_w", weights_o, part_w);

    // Same partial load under random stalls
    do_start(3, 1);
    repeat (20) begin
      @(negedge clk);
      in_valid = 0;
      chk("stall_ready", W'(in_ready), W'(1));
    end
    run_beats(1);
    do_swap(0, 0, 0);
    chk("stall_w", weights_o, part_w);

    // Abort after 3 beats keeps the committed bank
    d0 = done_cnt;
    bq.delete();
    bq.push_back(16'hFFFF);
    bq.push_back(16'h0001);
    bq.push_back(16'hFFFF);
    do_start(15, 7);
    run_beats(0);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_ready", W'(in_ready), W'(0));
    repeat (3) @(negedge clk);
    chk("abort_w", weights_o, part_w);
    chk("abort_done", W'(done_cnt - d0), W'(0));

    // Ignored swap in MSB and ignored start in FULL
    bq.delete();
    for (int i = 0; i < 6; i++) bq.push_back(16'($urandom));
    exp_w = model(5, 2, e);
    do_start(5, 2);
    @(negedge clk);
    swap = 1;
    @(negedge clk);
    swap = 0;
    repeat (2) @(negedge clk);
    chk("ign_swap_w", weights_o, part_w);
    chk("ign_swap_rdy", W'(in_ready), W'(1));
    run_beats(0);
    @(negedge clk);
    start = 1;
    cfg_rows = 4'd0;
    cfg_cols = 3'd0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("ign_start_busy", W'(busy), W'(1));
    chk("ign_start_rdy", W'(in_ready), W'(0));
    chk("ign_start_w", weights_o, part_w);
    chk("ign_err", W'(err), W'(e));
    do_swap(0, 0, 0);
    chk("ign_final_w", weights_o, exp_w);
    held_w = exp_w;

    // Reset during LSB, then a clean all +1 load
    bq.delete();
    bq.push_back(16'hFFFF);
    do_start(15, 7);
    run_beats(0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("mid_rst_w", weights_o, '0);
    chk("mid_rst_busy", W'(busy), W'(0));
    chk("mid_rst_rdy", W'(in_ready), W'(0));
    bq.delete();
    for (int i = 0; i < 8; i++) begin
      bq.push_back(16'h0000);
      bq.push_back(16'hFFFF);
    end
    exp_w = '0;
    for (int i = 0; i < IN * OUT; i++) exp_w[2*i +: 2] = 2'b01;
    do_start(15, 7);
    run_beats(0);
    chk("pos_err", W'(err), W'(0));
    do_swap(0, 0, 0);
    chk("pos_w", weights_o, exp_w);
    chk("pos_not_old", W'(weights_o == held_w), W'(0));

    // Random back-to-back loads against the model
    rr = $urandom_range(0, 15);
    rc = $urandom_range(0, 7);
    do_start(rr, rc);
    for (int k = 0; k < 5; k++) begin
      bq.delete();
      for (int i = 0; i < 2 * (rc + 1); i++) bq.push_back(16'($urandom));
      exp_w = model(rr, rc, e);
      d0 = done_cnt;
      run_beats(k[0]);
      chk("rnd_err", W'(err), W'(e));
      nr = $urandom_range(0, 15);
      nc = $urandom_range(0, 7);
      do_swap(k < 4, nr, nc);
      chk("rnd_w", weights_o, exp_w);
      chk("rnd_done", W'(done_cnt - d0), W'(1));
      chk("rnd_b2b_busy", W'(busy), W'(k < 4));
      rr = nr;
      rc = nc;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
